// File: rtl/alarm_pkg.sv
// Shared types and default parameters for the alarm tone generator.
package alarm_pkg;

    localparam int unsigned MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        SWEEP    = 2'd0,
        SAW      = 2'd1,
        TWO_TONE = 2'd2,
        PULSED   = 2'd3
    } alarm_mode_e;

    localparam int unsigned DEF_DIV_W      = 15;
    localparam int unsigned DEF_RAMP_W     = 7;
    localparam int unsigned DEF_STEP_W     = 19;
    localparam int unsigned DEF_PERIOD_MIN = 32'h4000;
    localparam int unsigned DEF_STEP_SHIFT = 6;

endpackage

// File: rtl/alarm_tone_gen_if.sv
// Control/status bundle between the alarm controller and the tone generator.
interface alarm_tone_gen_if #(
    parameter int unsigned RAMP_W = alarm_pkg::DEF_RAMP_W
);
    logic                          en;
    logic [alarm_pkg::MODE_W-1:0]  mode;
    logic                          beep;
    logic [RAMP_W-1:0]             level;
    logic                          active;

    modport master (output en, output mode, input beep, input level, input active);
    modport slave  (input en, input mode, output beep, output level, output active);
endinterface

// File: rtl/alarm_ramp.sv
// Step timer and pattern ramp: advances the ramp once per 2^STEP_W cycles.
module alarm_ramp
    import alarm_pkg::*;
#(
    parameter int unsigned RAMP_W = DEF_RAMP_W,
    parameter int unsigned STEP_W = DEF_STEP_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  alarm_mode_e       mode_q,
    output logic [RAMP_W-1:0] ramp,
    output logic              step_tick_c
);

    localparam logic [RAMP_W-1:0] RAMP_MAX = {RAMP_W{1'b1}};
    localparam logic [STEP_W-1:0] STEP_END = {STEP_W{1'b1}};

    logic [STEP_W-1:0] step_q;
    logic [RAMP_W-1:0] ramp_q;
    logic [RAMP_W-1:0] ramp_d;
    logic              dir_down_q;
    logic              dir_down_d;

    assign step_tick_c = ~clear & (step_q == STEP_END);
    assign ramp        = ramp_q;

    // Next ramp/direction: triangle for SWEEP with one-step endpoint hold, wrapping count otherwise
    always_comb begin
        ramp_d     = ramp_q;
        dir_down_d = dir_down_q;
        if (step_tick_c) begin
            case (mode_q)
                SWEEP: begin
                    if (!dir_down_q) begin
                        if (ramp_q == RAMP_MAX) begin
                            dir_down_d = 1'b1;
                            ramp_d     = RAMP_MAX - RAMP_W'(1);
                        end else begin
                            ramp_d = ramp_q + RAMP_W'(1);
                        end
                    end else begin
                        if (ramp_q == '0) begin
                            dir_down_d = 1'b0;
                            ramp_d     = RAMP_W'(1);
                        end else begin
                            ramp_d = ramp_q - RAMP_W'(1);
                        end
                    end
                end
                default: ramp_d = ramp_q + RAMP_W'(1);
            endcase
        end
    end

    // Timer and ramp registers; clear returns everything to the idle state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q     <= '0;
            ramp_q     <= '0;
            dir_down_q <= 1'b0;
        end else if (clear) begin
            step_q     <= '0;
            ramp_q     <= '0;
            dir_down_q <= 1'b0;
        end else begin
            step_q     <= step_q + STEP_W'(1);
            ramp_q     <= ramp_d;
            dir_down_q <= dir_down_d;
        end
    end

endmodule

// File: rtl/alarm_tone_gen.sv
// Square-wave alarm tone generator with four patterns and a ramp level output.
module alarm_tone_gen
    import alarm_pkg::*;
#(
    parameter int unsigned DIV_W      = DEF_DIV_W,
    parameter int unsigned RAMP_W     = DEF_RAMP_W,
    parameter int unsigned STEP_W     = DEF_STEP_W,
    parameter int unsigned PERIOD_MIN = DEF_PERIOD_MIN,
    parameter int unsigned STEP_SHIFT = DEF_STEP_SHIFT
) (
    input  logic       clk,
    input  logic       rst_n,
    alarm_tone_gen_if.slave bus
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ARMED = 1'b1;

    localparam longint unsigned TOP_PERIOD =
        longint'(PERIOD_MIN) + (((64'd1 << RAMP_W) - 64'd1) << STEP_SHIFT);
    localparam logic [DIV_W-1:0] PMIN = DIV_W'(PERIOD_MIN);

    // Slowest tone period must fit the period register
    if (TOP_PERIOD >= (64'd1 << DIV_W)) begin : g_cfg_check
        $error("alarm_tone_gen: PERIOD_MIN + ramp span overflows DIV_W");
    end

    logic [0:0]        state_q;
    logic [0:0]        state_d;
    logic              run_c;
    logic              arm_c;
    alarm_mode_e       mode_q;
    logic [RAMP_W-1:0] ramp;
    logic              unused_step_tick;
    logic [RAMP_W-1:0] tone_idx_c;
    logic [DIV_W-1:0]  target_c;
    logic              gate_c;
    logic [DIV_W-1:0]  cnt_q;
    logic [DIV_W-1:0]  cur_period_q;
    logic              beep_q;
    logic [RAMP_W-1:0] level_q;

    assign arm_c = (state_q == ST_IDLE) & bus.en;
    assign run_c = (state_q == ST_ARMED) & bus.en;

    // Arm/disarm state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Arm on en rising into idle, drop straight back to idle whenever en falls
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.en)  state_d = ST_ARMED;
            ST_ARMED: if (!bus.en) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Pattern is latched at arm and held until the next disarm
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      mode_q <= SWEEP;
        else if (!bus.en) mode_q <= SWEEP;
        else if (arm_c)  mode_q <= alarm_mode_e'(bus.mode);
    end

    alarm_ramp #(
        .RAMP_W (RAMP_W),
        .STEP_W (STEP_W)
    ) u_ramp (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (~run_c),
        .mode_q      (mode_q),
        .ramp        (ramp),
        .step_tick_c (unused_step_tick)
    );

    // Tone index and gate per pattern
    always_comb begin
        tone_idx_c = ramp;
        gate_c     = 1'b1;
        case (mode_q)
            TWO_TONE: tone_idx_c = {RAMP_W{ramp[RAMP_W-1]}};
            PULSED: begin
                tone_idx_c = '0;
                gate_c     = ~ramp[RAMP_W-1];
            end
            default: tone_idx_c = ramp;
        endcase
    end

    assign target_c = PMIN + (DIV_W'(tone_idx_c) << STEP_SHIFT);

    // Tone counter; the period only reloads at a wrap so tone cycles are never cut short
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            cur_period_q <= PMIN;
        end else if (!run_c) begin
            cnt_q        <= '0;
            cur_period_q <= PMIN;
        end else if (cnt_q == cur_period_q) begin
            cnt_q        <= '0;
            cur_period_q <= target_c;
        end else begin
            cnt_q        <= cnt_q + DIV_W'(1);
        end
    end

    // Registered buzzer drive and breathing-light level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beep_q  <= 1'b0;
            level_q <= '0;
        end else begin
            beep_q  <= run_c & gate_c & (cnt_q <= (cur_period_q >> 1));
            level_q <= run_c ? ramp : '0;
        end
    end

    assign bus.beep   = beep_q;
    assign bus.level  = level_q;
    assign bus.active = (state_q == ST_ARMED);

endmodule

// File: tb/tb_alarm_tone_gen.sv
// Randomized directed bench for alarm_tone_gen against a closed-form pattern model.
module tb_alarm_tone_gen;
    import alarm_pkg::*;

    localparam int unsigned DIV_W      = 8;
    localparam int unsigned RAMP_W     = 3;
    localparam int unsigned STEP_W     = 4;
    localparam int unsigned PERIOD_MIN = 8;
    localparam int unsigned STEP_SHIFT = 1;

    localparam int RMAX      = (1 << RAMP_W) - 1;
    localparam int HALF      = (1 << (RAMP_W - 1));
    localparam int STEP_LEN  = (1 << STEP_W);
    localparam int SWEEP_LEN = 2 * RMAX;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    alarm_tone_gen_if #(.RAMP_W(RAMP_W)) bus ();

    alarm_tone_gen #(
        .DIV_W      (DIV_W),
        .RAMP_W     (RAMP_W),
        .STEP_W     (STEP_W),
        .PERIOD_MIN (PERIOD_MIN),
        .STEP_SHIFT (STEP_SHIFT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: time since first armed cycle, phase and length of current tone cycle
    bit m_active;
    int m_mode;
    int m_t;
    int m_ph;
    int m_per;
    bit e_beep;
    int e_level;

    // Ramp value after t armed cycles, straight from the pattern definition
    function automatic int ramp_at(input int t, input int md);
        int n;
        int p;
        n = t / STEP_LEN;
        if (md == 0) begin
            p = n % SWEEP_LEN;
            return (p <= RMAX) ? p : SWEEP_LEN - p;
        end
        return n % (RMAX + 1);
    endfunction

    function automatic int period_for(input int r, input int md);
        int idx;
        case (md)
            0, 1:    idx = r;
            2:       idx = (r >= HALF) ? RMAX : 0;
            default: idx = 0;
        endcase
        return int'(PERIOD_MIN) + idx * (1 << STEP_SHIFT);
    endfunction

    function automatic bit gate_for(input int r, input int md);
        return (md == 3) ? (r < HALF) : 1'b1;
    endfunction

    task automatic model_step(input bit e, input int md);
        int r;
        if (!e) begin
            m_active = 1'b0;
            e_beep   = 1'b0;
            e_level  = 0;
        end else if (!m_active) begin
            m_active = 1'b1;
            m_mode   = md;
            m_t      = 0;
            m_ph     = 0;
            m_per    = int'(PERIOD_MIN);
            e_beep   = 1'b0;
            e_level  = 0;
        end else begin
            r       = ramp_at(m_t, m_mode);
            e_level = r;
            e_beep  = gate_for(r, m_mode) && (m_ph <= m_per / 2);
            if (m_ph == m_per) begin
                m_ph  = 0;
                m_per = period_for(r, m_mode);
            end else begin
                m_ph++;
            end
            m_t++;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s mode=%0d t=%0d got %0d expected %0d", tag, m_mode, m_t, got, exp);
        end
    endtask

    task automatic tick();
        bit e;
        int md;
        e  = bus.en;
        md = int'(bus.mode);
        @(posedge clk);
        model_step(e, md);
        #1;
        check("active", 32'(bus.active), 32'(m_active));
        check("beep",   32'(bus.beep),   32'(e_beep));
        check("level",  32'(bus.level),  32'(e_level));
    endtask

    // Run n cycles; optionally wiggle mode while armed (must be ignored)
    task automatic run(input int n, input bit jitter);
        for (int i = 0; i < n; i++) begin
            tick();
            if (jitter && m_active && ($urandom_range(0, 7) == 0))
                bus.mode = 2'($urandom_range(0, 3));
        end
    endtask

    task automatic arm(input int md);
        bus.mode = 2'(md);
        bus.en   = 1'b1;
        tick();
    endtask

    task automatic disarm(input int n);
        bus.en = 1'b0;
        run(n, 1'b0);
    endtask

    initial begin
        int guard;
        rst_n    = 1'b0;
        bus.en   = 1'b0;
        bus.mode = 2'd0;
        m_active = 1'b0;
        m_mode   = 0;
        m_t      = 0;
        m_ph     = 0;
        m_per    = int'(PERIOD_MIN);
        e_beep   = 1'b0;
        e_level  = 0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_active", 32'(bus.active), 32'd0);
        check("rst_beep",   32'(bus.beep),   32'd0);
        check("rst_level",  32'(bus.level),  32'd0);
        rst_n = 1'b1;

        // Idle after reset
        run(50, 1'b0);

        // Full sweep up/down and back, with mode noise while armed
        arm(0);
        run(2 * SWEEP_LEN * STEP_LEN + 40, 1'b1);

        // Sawtooth through the 7->0 wrap twice
        disarm(1 + $urandom_range(0, 3));
        arm(1);
        run(2 * (RMAX + 1) * STEP_LEN + 30, 1'b1);

        // Two-tone
        disarm(1 + $urandom_range(0, 3));
        arm(2);
        run(2 * (RMAX + 1) * STEP_LEN + 30, 1'b1);

        // Pulsed
        disarm(1 + $urandom_range(0, 3));
        arm(3);
        run(2 * (RMAX + 1) * STEP_LEN + 30, 1'b1);

        // Drop en at cnt=3 of a later tone cycle, change mode while off, rearm 5 cycles later
        disarm(2);
        arm(0);
        guard = 0;
        while (!(m_ph == 3 && m_t > 10) && guard <= 200) begin
            tick();
            guard++;
        end
        n_tests++;
        assert (guard <= 200) else begin
            n_fail++;
            $error("FAIL wait_cnt3 got %0d cycles expected at most %0d", guard, 200);
        end
        bus.en   = 1'b0;
        bus.mode = 2'd1;
        run(5, 1'b0);
        arm(1);
        run(3 * STEP_LEN + 20, 1'b1);

        // Random episodes
        for (int ep = 0; ep < 12; ep++) begin
            disarm(1 + $urandom_range(0, 5));
            arm($urandom_range(0, 3));
            run($urandom_range(20, 400), 1'b1);
        end
        disarm(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alarm_tone_gen.md
Name: alarm_tone_gen

Overview:
- Parametrised successor to the fixed siren buzzer: square-wave tone generator with four selectable alarm patterns.
- Patterns: triangle sweep, sawtooth sweep, two-tone, pulsed.
- Adds enable/arm control, glitch-free period updates, and exports the ramp value as `level` to drive the breathing-light PWM.
- Sits between the alarm controller (drives `en`/`mode`) and the buzzer pin / LED PWM block.

Parameters:
- DIV_W, 15: width of tone period counter and period register.
- RAMP_W, 7: width of ramp/level value.
- STEP_W, 19: width of step timer; ramp advances once every 2^STEP_W clk cycles.
- PERIOD_MIN, 15'h4000: tone period value at ramp index 0 (period value P gives P+1 clk cycles per tone cycle).
- STEP_SHIFT, 6: left shift applied to tone index before adding to PERIOD_MIN.
- Constraint: PERIOD_MIN + ((2^RAMP_W - 1) << STEP_SHIFT) < 2^DIV_W. Checked by elaboration-time assertion.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- en  in  1  level enable; alarm runs while high.
- mode  in  2  pattern select: 0 SWEEP, 1 SAW, 2 TWO_TONE, 3 PULSED; sampled only at arm.
- beep  out  1  registered buzzer drive.
- level  out  RAMP_W  current ramp value (registered), for breathing light.
- active  out  1  high while alarm is armed.

Behaviour:
- Reset values: beep=0, active=0, level=0. Internal state on reset:
  - step timer=0, ramp=0, dir=up, cnt=0, cur_period=PERIOD_MIN, mode_q=0.
- Arm: in the cycle where en=1 and active=0:
  - active<=1, mode_q<=mode.
  - step timer, ramp, cnt <= 0; dir<=up; cur_period<=PERIOD_MIN.
- Disarm: en=0 at any cycle gives next cycle active=0, beep=0, level=0, and all internal state returns to reset values.
  - en=0 mid-tone or mid-step truncates immediately; no completion of the current cycle.
- mode changes while active are ignored until the next arm.
- Step timer: STEP_W-bit free-running counter while active. step_tick asserts when it equals all-ones, then it wraps to 0.
- Ramp update on step_tick:
  - SWEEP: count up 0..max, then down max..0. At max with dir=up: dir<=down, ramp<=max-1. At 0 with dir=down: dir<=up, ramp<=1. Endpoints are held for exactly one step.
  - SAW: ramp+1, wrapping max to 0.
  - TWO_TONE, PULSED: ramp+1 wrapping, same as SAW.
- Tone index (combinational from ramp and mode_q):
  - SWEEP, SAW: ramp.
  - TWO_TONE: all bits = ramp[MSB], so only 0 or max.
  - PULSED: 0.
- Target period = PERIOD_MIN + (tone_index << STEP_SHIFT), DIV_W bits, no overflow by constraint.
- Tone counter cnt counts 0..cur_period, then wraps to 0.
  - cur_period loads the target period only in the cycle cnt==cur_period (wrap), so there are never partial or glitched tone cycles.
  - A step_tick coinciding with a wrap: the wrap loads the target computed from the pre-tick ramp. The new ramp takes effect at the following wrap.
- Gate: 1, except PULSED where gate = ~ramp[MSB] (silent for the upper half of ramp range).
- beep <= active & gate & (cnt <= cur_period >> 1).
  - High for floor(P/2)+1 cycles, low for the remainder of P+1.
  - Registered, so one cycle latency from cnt.
- level <= ramp, registered: one cycle behind ramp; 0 when inactive.
- First-cycle timing after arm (cycle A): active=1 at A+1. At A+1 cnt=0 and active is seen at the register, so beep=1 first at A+2.

Decomposition:
- alarm_pkg contains:
  - mode enum alarm_mode_e: SWEEP=0, SAW=1, TWO_TONE=2, PULSED=3.
  - default parameter constants.
- Sub-module alarm_ramp holds step timer, ramp, dir, mode-dependent update.
  - Outputs: ramp, step_tick.
  - Inputs: clear and mode_q.
- Top holds arm logic, period mux, tone counter, beep/level registers.

Test Plan (bench params: DIV_W=8, RAMP_W=3, STEP_W=4, PERIOD_MIN=8, STEP_SHIFT=1):
- Reset with en=0 → beep=0, level=0, active=0 held for 50 cycles.
- Arm SWEEP, en held → active=1 one cycle after arm; beep=1 one cycle later. First tone cycle 9 clks (5 high, 4 low). level steps 0,1,..,7,6,..,0,1 every 16 clks, each endpoint held exactly 16 clks.
- SAW, run past level 7 → level wraps 7→0. Tone period at ramp=7 is 23 clks (12 high/11 low); next wrap after level=0 returns to 9 clks, with no truncated cycle.
- TWO_TONE → tone cycles only 9 or 23 clks. Switches after level crosses 3→4 and 7→0, only at tone-cycle boundaries.
- PULSED → 9-clk tone while level 0..3. beep=0 throughout level 4..7 (64 clks). Repeats.
- en dropped mid-tone at cnt=3, mode changed to SAW, en raised 5 cycles later → beep=0 and level=0 within one cycle of drop. Rearm restarts at cnt=0/level=0 in SAW. A mode change while active has no effect.
